md5_core: RTL and testbench
===========================

# md5_core

Fully pipelined, single-block MD5 compression core. It accepts one pre-padded 512-bit block per enabled clock and returns the 128-bit digest state, computed from the standard MD5 IV, 65 enabled cycles later. The input block travels alongside the result so downstream logic (candidate matching / reporting) can identify which message produced each digest. It sits between the message generator and the digest comparator in the hash datapath.

## Interface
- No parameters; all MD5 constants are fixed.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `en` in 1: global pipeline enable; when 0 every register holds.
- `m_in` in 512: pre-padded block; byte 0 of the message is `m_in[511:504]`.
- `valid_in` in 1: `m_in` is a real block this cycle.
- `a_out`, `b_out`, `c_out`, `d_out` out 32 each: final MD5 state words, with the IV already added.
- `m_out` out 512: copy of the `m_in` that produced the current outputs.
- `valid_out` out 1: outputs hold a completed digest.

## Operation
- Word extraction: MD5 word M[i] (i = 0..15) is the little-endian assembly of bytes 4i..4i+3, where byte k = `m_in[511-8k -: 8]`.
  - Example: M[0] = {byte3, byte2, byte1, byte0}.
- IV: A=0x67452301, B=0xefcdab89, C=0x98badcfe, D=0x10325476.
- Rounds: 64 standard MD5 steps, one pipeline stage per step.
  - Step i uses F/G/H/I by quarter, K[i] = floor(abs(sin(i+1))·2^32), the standard shift table, and message index i, (5i+1)%16, (3i+5)%16, (7i)%16 by quarter.
  - Per step: new B = B + rotl(A + f + K[i] + M[g], s[i]); A←D, D←C, C←B.
- All arithmetic is mod 2^32; no saturation.
- Final stage: registered add of the IV to each word, producing `a_out`..`d_out`.
  - Digest bytes = little-endian of a, b, c, d concatenated.
- Each stage register carries {a, b, c, d, 512-bit message, valid}. The block is not re-read from the input port.
- Bubbles (`valid_in`=0) propagate as valid=0. Data fields of bubbles are don't-care but still deterministic.
- No backpressure. `en` is the only stall; a new block is accepted every enabled cycle.
- Single 512-bit block only. Multi-block chaining is out of scope.

## Timing
- Latency: a block sampled with `valid_in`=1 on enabled edge N appears with `valid_out`=1 after exactly 65 enabled edges.
  - 64 round stages plus 1 IV-add/output stage.
- Throughput: 1 block per enabled cycle. Back-to-back blocks emerge on consecutive enabled cycles in order.
- `en`=0: inputs are ignored and all stages, including outputs, hold their values. Latency counts only enabled edges.
- Reset (asserted low, asynchronous): all stage registers and all outputs go to 0, including `valid_out`.
  - Reset mid-operation discards every in-flight block.
  - The first valid output after release appears 65 enabled edges after the first accepted block.
- `valid_in` with `en`=0 is not captured.

## Structure
- Shared package `md5_pkg` holds:
  - K[0:63] table, shift table s[0:63], IV constants.
  - Message-index function g(i) and byte-swap word-extract function.
  - Round function selector.
- One sub-module, `md5_step`: a single registered step parameterised by step index, instantiated 64 times via generate.
  - It carries a, b, c, d, m and valid with `en` and the asynchronous active-low `reset`.
- Top level contains the generate chain plus the final IV-add output register.

## Test plan
- Reset: assert reset low mid-stream -> all outputs 0, `valid_out`=0 immediately (asynchronous); in-flight blocks lost.
- Single block "The quick brown fox jumps over the lazy dog", padded with length 0x158 bits:
  - Required: `valid_out`=1 65 enabled cycles later.
  - `a_out`=0x9d7d109e, `b_out`=0x82b62b37, `c_out`=0x351dd86b, `d_out`=0xd619a442.
  - `m_out` equals the input block.
- Back-to-back: fox block then "Hello World" block (length 0x58) on consecutive cycles:
  - Required: fox digest, then on the next cycle `a_out`=0xb18d0ab1, `b_out`=0x4175e064, `c_out`=0x9ba9b705, `d_out`=0xe53f2ee7, with `valid_out` high for exactly 2 cycles.
- Empty message (block 0x80 followed by zeros):
  - Required digest words 0xd98c1dd4, 0x04b2008f, 0x980980e9, 0x7e42f8ec.
- Stall: drop `en` for 10 cycles while a block is in flight -> outputs frozen during the stall; digest appears 10 cycles later than unstalled; values unchanged.
- Bubble: `valid_in`=0 with nonzero `m_in` -> `valid_out` stays 0 at the corresponding output slot.

Source files
------------

// File: rtl/md5_pkg.sv
// Shared MD5 constants and per-step helper functions for the pipelined
// compression core: round constants, shift amounts, IV and word selection.
package md5_pkg;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [31:0] K [0:63] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  localparam int unsigned S [0:63] = '{
    7, 12, 17, 22, 7, 12, 17, 22, 7, 12, 17, 22, 7, 12, 17, 22,
    5,  9, 14, 20, 5,  9, 14, 20, 5,  9, 14, 20, 5,  9, 14, 20,
    4, 11, 16, 23, 4, 11, 16, 23, 4, 11, 16, 23, 4, 11, 16, 23,
    6, 10, 15, 21, 6, 10, 15, 21, 6, 10, 15, 21, 6, 10, 15, 21
  };

  function automatic int unsigned msg_index(input int unsigned step);
    case (step / 16)
      0:       return step;
      1:       return (5 * step + 1) % 16;
      2:       return (3 * step + 5) % 16;
      default: return (7 * step) % 16;
    endcase
  endfunction

  // Message bytes arrive big-end first on the bus; MD5 words are little-endian.
  function automatic logic [31:0] msg_word(input logic [511:0] m, input int unsigned idx);
    logic [31:0] w;
    w = m[511 - 32 * idx -: 32];
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [31:0] round_f(input int unsigned step, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
    case (step / 16)
      0:       return (b & c) | (~b & d);
      1:       return (d & b) | (~d & c);
      2:       return b ^ c ^ d;
      default: return c ^ (b | ~d);
    endcase
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    logic [63:0] xx;
    xx = {x, x} << n;
    return xx[63:32];
  endfunction

endpackage

// File: rtl/md5_step.sv
// One registered MD5 step; the message block and valid flag ride along
// so every stage is self-contained.
module md5_step
  import md5_pkg::*;
#(
  parameter int unsigned STEP = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [31:0]  a,
  input  logic [31:0]  b,
  input  logic [31:0]  c,
  input  logic [31:0]  d,
  input  logic [511:0] m,
  input  logic         valid,
  output logic [31:0]  a_q,
  output logic [31:0]  b_q,
  output logic [31:0]  c_q,
  output logic [31:0]  d_q,
  output logic [511:0] m_q,
  output logic         valid_q
);

  localparam int unsigned G = msg_index(STEP);

  logic [31:0] sum;
  logic [31:0] b_next;

  always_comb begin
    sum    = a + round_f(STEP, b, c, d) + K[STEP] + msg_word(m, G);
    b_next = b + rotl(sum, S[STEP]);
  end

  // step register: rotate the state words, carry block and valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      m_q     <= '0;
      valid_q <= 1'b0;
    end else if (en) begin
      a_q     <= d;
      b_q     <= b_next;
      c_q     <= b;
      d_q     <= c;
      m_q     <= m;
      valid_q <= valid;
    end
  end

endmodule

// File: rtl/md5_core.sv
// Fully pipelined single-block MD5: 64 step stages seeded with the IV,
// followed by a registered IV add that drives the digest outputs.
module md5_core
  import md5_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [511:0] m_in,
  input  logic         valid_in,
  output logic [31:0]  a_out,
  output logic [31:0]  b_out,
  output logic [31:0]  c_out,
  output logic [31:0]  d_out,
  output logic [511:0] m_out,
  output logic         valid_out
);

  logic [31:0]  a_p   [0:64];
  logic [31:0]  b_p   [0:64];
  logic [31:0]  c_p   [0:64];
  logic [31:0]  d_p   [0:64];
  logic [511:0] m_p   [0:64];
  logic         vld_p [0:64];

  assign a_p[0]   = IV_A;
  assign b_p[0]   = IV_B;
  assign c_p[0]   = IV_C;
  assign d_p[0]   = IV_D;
  assign m_p[0]   = m_in;
  assign vld_p[0] = valid_in;

  for (genvar i = 0; i < 64; i++) begin : g_step
    md5_step #(.STEP(i)) u_step (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .a       (a_p[i]),
      .b       (b_p[i]),
      .c       (c_p[i]),
      .d       (d_p[i]),
      .m       (m_p[i]),
      .valid   (vld_p[i]),
      .a_q     (a_p[i+1]),
      .b_q     (b_p[i+1]),
      .c_q     (c_p[i+1]),
      .d_q     (d_p[i+1]),
      .m_q     (m_p[i+1]),
      .valid_q (vld_p[i+1])
    );
  end

  // output stage: fold the IV back in
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_out     <= '0;
      b_out     <= '0;
      c_out     <= '0;
      d_out     <= '0;
      m_out     <= '0;
      valid_out <= 1'b0;
    end else if (en) begin
      a_out     <= a_p[64] + IV_A;
      b_out     <= b_p[64] + IV_B;
      c_out     <= c_p[64] + IV_C;
      d_out     <= d_p[64] + IV_D;
      m_out     <= m_p[64];
      valid_out <= vld_p[64];
    end
  end

endmodule

// File: tb/tb_md5_core.sv
// Bench for md5_core: directed known-answer, latency, stall, bubble and reset
// steps, then randomized traffic checked against a loop-style MD5 model.
module tb_md5_core;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         valid_in = 1'b0;
  logic [511:0] m_in = '0;
  logic [31:0]  a_out, b_out, c_out, d_out;
  logic [511:0] m_out;
  logic         valid_out;

  md5_core dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .m_in      (m_in),
    .valid_in  (valid_in),
    .a_out     (a_out),
    .b_out     (b_out),
    .c_out     (c_out),
    .d_out     (d_out),
    .m_out     (m_out),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] kt [64];
  int unsigned sq [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20},
                             '{4, 11, 16, 23}, '{6, 10, 15, 21}};

  typedef struct packed {
    logic         v;
    logic [511:0] m;
  } ent_t;
  ent_t q[$];

  logic [511:0] fox_blk, hello_blk, empty_blk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] make_block(input string s);
    logic [511:0] blk;
    logic [63:0]  bits;
    int n;
    blk  = '0;
    n    = s.len();
    bits = 64'(n) * 64'd8;
    for (int k = 0; k < n; k++) blk[511 - 8 * k -: 8] = s[k];
    blk[511 - 8 * n -: 8] = 8'h80;
    for (int j = 0; j < 8; j++) blk[511 - 8 * (56 + j) -: 8] = bits[8 * j +: 8];
    return blk;
  endfunction

  function automatic logic [127:0] md5_ref(input logic [511:0] blk);
    logic [31:0] w [16];
    logic [31:0] a, b, c, d, f, t, nb;
    int unsigned g, sh;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 4; j++)
        w[i][8 * j +: 8] = blk[511 - 8 * (4 * i + j) -: 8];
    a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0:       begin f = (b & c) | (~b & d); g = i; end
        1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
        2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
        default: begin f = c ^ (b | ~d);       g = (7 * i) % 16; end
      endcase
      sh = sq[i / 16][i % 4];
      t  = a + f + kt[i] + w[g];
      nb = b + ((t << sh) | (t >> (32 - sh)));
      a = d; d = c; c = b; b = nb;
    end
    return {a + 32'h67452301, b + 32'hefcdab89, c + 32'h98badcfe, d + 32'h10325476};
  endfunction

  task automatic tick();
    ent_t e;
    if (en && reset) begin
      e.v = valid_in;
      e.m = m_in;
      q.push_back(e);
      if (q.size() > 65) void'(q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_digest(input string tag, input logic [127:0] dig, input logic [511:0] blk);
    chk({tag, "_valid"}, valid_out, 1'b1);
    chk({tag, "_a"}, a_out, dig[127:96]);
    chk({tag, "_b"}, b_out, dig[95:64]);
    chk({tag, "_c"}, c_out, dig[63:32]);
    chk({tag, "_d"}, d_out, dig[31:0]);
    chk({tag, "_m"}, m_out, blk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, valid_out, 1'b0);
    chk({tag, "_a"}, a_out, 32'h0);
    chk({tag, "_b"}, b_out, 32'h0);
    chk({tag, "_c"}, c_out, 32'h0);
    chk({tag, "_d"}, d_out, 32'h0);
    chk({tag, "_m"}, m_out, 512'h0);
  endtask

  task automatic check_model(input string tag);
    logic exp_v;
    exp_v = (q.size() == 65) ? q[0].v : 1'b0;
    chk({tag, "_valid"}, valid_out, exp_v);
    if (exp_v) check_digest(tag, md5_ref(q[0].m), q[0].m);
  endtask

  initial begin
    real r;
    for (int i = 0; i < 64; i++) begin
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      kt[i] = 32'(longint'($floor(r * 4294967296.0)));
    end
    fox_blk   = make_block("The quick brown fox jumps over the lazy dog");
    hello_blk = make_block("Hello World");
    empty_blk = make_block("");

    // asynchronous reset from power-up
    #2 reset = 1'b0;
    #2 check_zero("reset_init");
    tick_n(2);
    #3 reset = 1'b1;
    tick();
    en = 1'b1;

    // single fox block, exact latency
    m_in = fox_blk; valid_in = 1'b1;
    tick();
    m_in = '0; valid_in = 1'b0;
    tick_n(63);
    chk("fox_early_valid", valid_out, 1'b0);
    tick();
    check_digest("fox", {32'h9d7d109e, 32'h82b62b37, 32'h351dd86b, 32'hd619a442}, fox_blk);
    tick();
    chk("fox_after_valid", valid_out, 1'b0);

    // back-to-back fox then hello
    m_in = fox_blk; valid_in = 1'b1;
    tick();
    m_in = hello_blk;
    tick();
    m_in = '0; valid_in = 1'b0;
    tick_n(62);
    chk("b2b_early_valid", valid_out, 1'b0);
    tick();
    check_digest("b2b_fox", {32'h9d7d109e, 32'h82b62b37, 32'h351dd86b, 32'hd619a442}, fox_blk);
    tick();
    check_digest("b2b_hello", {32'hb18d0ab1, 32'h4175e064, 32'h9ba9b705, 32'he53f2ee7}, hello_blk);
    tick();
    chk("b2b_after_valid", valid_out, 1'b0);

    // empty message
    m_in = empty_blk; valid_in = 1'b1;
    tick();
    m_in = '0; valid_in = 1'b0;
    tick_n(64);
    check_digest("empty", {32'hd98c1dd4, 32'h04b2008f, 32'h980980e9, 32'h7e42f8ec}, empty_blk);

    // stall mid-flight; inputs offered during the stall must be ignored
    m_in = fox_blk; valid_in = 1'b1;
    tick();
    m_in = '0; valid_in = 1'b0;
    tick_n(30);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      m_in = {16{$urandom()}}; valid_in = 1'b1;
      tick();
      chk("stall_valid", valid_out, 1'b0);
    end
    en = 1'b1; m_in = '0; valid_in = 1'b0;
    tick_n(33);
    chk("stall_early_valid", valid_out, 1'b0);
    tick();
    check_digest("stall", {32'h9d7d109e, 32'h82b62b37, 32'h351dd86b, 32'hd619a442}, fox_blk);
    en = 1'b0; m_in = hello_blk; valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_digest("frozen", {32'h9d7d109e, 32'h82b62b37, 32'h351dd86b, 32'hd619a442}, fox_blk);
    end
    en = 1'b1; m_in = '0; valid_in = 1'b0;
    tick();
    chk("unstall_valid", valid_out, 1'b0);

    // bubble with nonzero data
    m_in = hello_blk; valid_in = 1'b0;
    tick();
    m_in = '0;
    tick_n(64);
    chk("bubble_valid", valid_out, 1'b0);

    // reset mid-stream drops the in-flight block
    m_in = fox_blk; valid_in = 1'b1;
    tick();
    m_in = '0; valid_in = 1'b0;
    tick_n(20);
    #2 reset = 1'b0;
    #1 check_zero("reset_mid");
    q.delete();
    tick();
    #2 reset = 1'b1;
    for (int i = 0; i < 70; i++) begin
      tick();
      check_model("post_reset");
    end

    // randomized traffic with random stalls and bubbles
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      valid_in = $urandom_range(0, 1) != 0;
      m_in     = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      check_model("rand");
    end
    en = 1'b1; valid_in = 1'b0; m_in = '0;
    for (int i = 0; i < 66; i++) begin
      tick();
      check_model("drain");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
